sign_compress_tx: RTL
=====================

Name: sign_compress_tx

Overview:
- Transmit-side counterpart of the 8-to-16 sign extender: accepts 16-bit words and emits them on an 8-bit byte stream.
- A word whose upper byte is the sign replication of bit 7 is sent as one tagged "short" byte; the receiver sign-extends it back.
- Any other word is sent as two bytes, low byte first.
- Sits between the register-file/immediate path and the narrow 8-bit peripheral/memory port.

Parameters:
- WORD_W, 16, input word width; must equal 2*BYTE_W.
- BYTE_W, 8, output byte width.
- CNT_W, 16, width of the statistics counters (see Optional Feature).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_word  in  WORD_W  word to transmit
- in_valid  in  1  in_word valid
- in_ready  out  1  block can accept a word this cycle
- out_byte  out  BYTE_W  byte on the stream
- out_short  out  1  1 = single-byte frame (receiver sign-extends); 0 = part of a two-byte frame
- out_last  out  1  final byte of the frame
- out_valid  out  1  out_byte/out_short/out_last valid
- out_ready  in  1  downstream accepts the byte
- short_cnt  out  CNT_W  short frames sent (feature only)
- long_cnt  out  CNT_W  long frames sent (feature only)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; out_valid=0, out_byte=0, out_short=0, out_last=0; hold register cleared; counters=0.
  - in_ready=0 while rst_n=0.
- Compressibility: compressible iff in_word[15:8] == {8{in_word[7]}}.
  - 0x0000, 0x007F, 0xFF80 and 0xFFFF are short.
  - 0x0080, 0x00F0 and 0xFF7F are long.
- States:
  - IDLE: no output byte pending.
  - SHORT: presenting the single-byte frame.
  - LONG_LO: presenting the low byte of a long frame.
  - LONG_HI: presenting the high byte of a long frame.
- Accept = in_valid & in_ready. On accept, the word is latched into the hold register and, at the next edge:
  - compressible: SHORT; out_byte=word[7:0], out_short=1, out_last=1.
  - otherwise: LONG_LO; out_byte=word[7:0], out_short=0, out_last=0.
  - out_valid=1 in either case.
- Latency: accept at edge N gives out_valid=1 after edge N+1. Outputs are registered.
- LONG_LO with out_ready=1 → LONG_HI at the next edge; out_byte=word[15:8], out_short=0, out_last=1.
- SHORT or LONG_HI with out_ready=1 (last byte taken):
  - IDLE if no accept in the same cycle;
  - otherwise directly into SHORT/LONG_LO for the new word (back-to-back, no bubble).
- in_ready = rst_n & (state==IDLE | (out_valid & out_last & out_ready)).
  - in_ready is combinational from state and out_ready; there is no path from in_valid.
- Throughput: 1 word/cycle if all short; 1 word/2 cycles if long.
- Backpressure: while out_valid & !out_ready, out_byte/out_short/out_last/state are held stable, and in_ready=0 unless in IDLE.
- in_word is sampled only on accept; later changes while busy are ignored.
- Reset mid-frame: the frame is dropped with no partial completion; the first cycle after rst_n rises is IDLE.

Optional Feature:
- Macro: SIGN_COMPRESS_STATS_EN.
- Defined:
  - short_cnt increments when a SHORT byte is accepted downstream.
  - long_cnt increments when a LONG_HI byte is accepted downstream.
  - Both saturate at 2^CNT_W-1 (no wrap) and clear on reset.
- Undefined: short_cnt and long_cnt are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, SHORT=2'd1, LONG_LO=2'd2, LONG_HI=2'd3;
  - WORD_W/BYTE_W defaults.
- One natural sub-module: sign_compressible, a pure combinational compressibility check, reusable by the matching receiver's checker.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, in_ready=0, counters 0; first cycle after release in_ready=1.
- Short: in_word=0xFF80, out_ready=1 → next cycle out_byte=0x80, out_short=1, out_last=1. Then 0x007F → 0x7F, short. Counters short_cnt=2, long_cnt=0.
- Long: in_word=0x00F0, out_ready=1 → bytes 0xF0 (short=0, last=0) then 0x00 (last=1). in_ready=0 during LONG_LO. long_cnt=1.
- Back-to-back: in_valid held with stream 0x0001, 0x1234, 0xFFFF and out_ready=1 →
  - bytes 0x01(S,L), 0x34, 0x12(L), 0xFF(S,L) on consecutive cycles;
  - no idle cycle between frames.
- Backpressure: send 0xFF7F with out_ready=0 for 3 cycles → out_byte=0x7F held, in_ready=0. Release → 0xFF with out_last=1.
- Reset mid-frame: rst_n=0 while in LONG_HI of 0x8000 → after release out_valid=0, state IDLE. The next word 0x0005 is emitted as a short frame 0x05.

Source files
------------

// File: rtl/sign_compress_tx_pkg.sv
// Shared constants for the sign-compressing byte transmitter and its receiver-side checker.
package sign_compress_tx_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int BYTE_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHORT   = 2'd1,
    ST_LONG_LO = 2'd2,
    ST_LONG_HI = 2'd3
  } state_e;

endpackage

// File: rtl/sign_compressible.sv
// A word is compressible when its upper byte is the sign replication of the lower byte's MSB.
module sign_compressible
  import sign_compress_tx_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic [2*BYTE_W-1:0] word,
  output logic                compressible
);

  assign compressible = (word[2*BYTE_W-1:BYTE_W] == {BYTE_W{word[BYTE_W-1]}});

endmodule

// File: rtl/sign_compress_tx.sv
// 16-bit word to 8-bit byte stream: sign-redundant words go out as one short byte, others as lo/hi.
// Optional frame counters under SIGN_COMPRESS_STATS_EN; otherwise short_cnt/long_cnt read 0.
module sign_compress_tx
  import sign_compress_tx_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_short,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  short_cnt,
  output logic [CNT_W-1:0]  long_cnt
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [BYTE_W-1:0]   out_byte_q, out_byte_d;
  logic                out_short_q, out_short_d;
  logic                out_last_q, out_last_d;
  logic                out_valid_q, out_valid_d;
  logic                in_compressible;
  logic                accept;

  sign_compressible #(
    .BYTE_W (BYTE_W)
  ) u_check (
    .word         (in_word),
    .compressible (in_compressible)
  );

  // A new word may enter only when nothing is pending or the last byte leaves this cycle.
  assign in_ready = rst_n & ((state_q == ST_IDLE) | (out_valid_q & out_last_q & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out_byte_d  = out_byte_q;
    out_short_d = out_short_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (state_q == ST_LONG_LO) begin
      if (out_ready) begin
        state_d    = ST_LONG_HI;
        out_byte_d = hold_q[WORD_W-1:BYTE_W];
        out_last_d = 1'b1;
      end
    end else if (accept) begin
      state_d     = in_compressible ? ST_SHORT : ST_LONG_LO;
      hold_d      = in_word;
      out_byte_d  = in_word[BYTE_W-1:0];
      out_short_d = in_compressible;
      out_last_d  = in_compressible;
      out_valid_d = 1'b1;
    end else if (out_ready && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      out_byte_q  <= '0;
      out_short_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_byte_q  <= out_byte_d;
      out_short_q <= out_short_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_byte  = out_byte_q;
  assign out_short = out_short_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

`ifdef SIGN_COMPRESS_STATS_EN
  logic [CNT_W-1:0] short_cnt_q, short_cnt_d;
  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;

  // Counters saturate rather than wrap so a stuck-high count is visible.
  always_comb begin
    short_cnt_d = short_cnt_q;
    long_cnt_d  = long_cnt_q;
    if (state_q == ST_SHORT && out_ready && short_cnt_q != {CNT_W{1'b1}})
      short_cnt_d = short_cnt_q + CNT_W'(1);
    if (state_q == ST_LONG_HI && out_ready && long_cnt_q != {CNT_W{1'b1}})
      long_cnt_d = long_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      short_cnt_q <= '0;
      long_cnt_q  <= '0;
    end else begin
      short_cnt_q <= short_cnt_d;
      long_cnt_q  <= long_cnt_d;
    end
  end

  assign short_cnt = short_cnt_q;
  assign long_cnt  = long_cnt_q;
`else
  assign short_cnt = '0;
  assign long_cnt  = '0;
`endif

endmodule
